system2_sweep_ctrl: RTL
=======================

Name: system2_sweep_ctrl

Overview:
Self-test sequencer for the 4-input combinational system2 block. On a start request it drives va/vb/vc/vd through all 16 input combinations in binary order, index 0 to 15.
- Each vector is held for a programmable settle time.
- outa is sampled once per vector into a 16-bit truth table.
- The table is compared against an expected pattern.
It sits beside system2 as its driver and replaces manual stimulus for in-system checking.

Parameters:
SETTLE_CYCLES, 2, number of idle cycles between applying a vector and sampling outa; 0..15 legal, 0 skips SETTLE.
EXPECTED, 16'h0000, expected truth table; bit i is the expected outa for vector index i.

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
start  input  1  sweep request; sampled only in IDLE
outa_in  input  1  outa from system2
va  output  1  vector bit 0 (index[0])
vb  output  1  vector bit 1 (index[1])
vc  output  1  vector bit 2 (index[2])
vd  output  1  vector bit 3 (index[3])
busy  output  1  high while a sweep is in progress (DRIVE/SETTLE/SAMPLE)
done  output  1  single-cycle pulse when a sweep completes
truth  output  16  captured truth table, bit i = outa for index i
pass  output  1  truth == EXPECTED, valid from done until the next start

Behaviour:
- One clock; reset is synchronous and active-high, on clk/rst. Reset values: va=vb=vc=vd=0, busy=0, done=0, truth=16'h0000, pass=0, state IDLE, index 0, settle count 0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: vector outputs are 0. When start=1, clear truth and pass, set index=0, and go to DRIVE.
- DRIVE (1 cycle): register {vd,vc,vb,va}=index. The vector stays stable through SETTLE and SAMPLE. Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE (1 cycle): truth[index] <= outa_in. If index==15, go to DONE; else index <= index+1 and go to DRIVE.
- DONE (1 cycle): done=1, pass <= (truth==EXPECTED), busy=0, vector outputs return to 0, then go to IDLE.
- busy=1 in DRIVE, SETTLE and SAMPLE.
- Timing, with the start-accept cycle as cycle 0:
  - Index i occupies cycles 1+i*(S+2) through (i+1)*(S+2), where S=SETTLE_CYCLES.
  - done is high in cycle 16*(S+2)+1, which is cycle 65 for S=2.
- start while busy or in DONE is ignored; no queuing.
- The index counter is 4 bits and stops at 15; it never wraps within a sweep.
- truth and pass hold their values after DONE until the next accepted start.
- rst mid-sweep: on the next edge all state returns to reset values, with no done pulse. The next start restarts from index 0.

Optional Feature:
Macro SYSTEM2_SWEEP_FAIL_IDX_EN.
- Defined: adds outputs fail_valid (1 bit) and fail_idx (4 bits). In SAMPLE, if outa_in != EXPECTED[index] and fail_valid==0, set fail_valid=1 and fail_idx=index. Both clear on reset and on accepted start, and hold after done.
- Undefined: these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package/include system2_sweep_pkg:
  - state encodings ST_IDLE, ST_DRIVE, ST_SETTLE, ST_SAMPLE, ST_DONE (3 bits)
  - NUM_VECTORS=16, VEC_W=4, CNT_W=4
- One natural sub-module, system2_settle_timer: loadable down-counter with a load input and a zero flag, parameterised by SETTLE_CYCLES. It is instantiated once.
- The FSM, index counter and truth register stay in the top module.

Test Plan:
1. Reset only: hold rst=1 for 3 cycles, then release -> va..vd=0, busy=0, done=0, truth=16'h0000, pass=0.
2. DUT model outa=va&vb&vc&vd, EXPECTED=16'h8000, S=2, start pulse at cycle 0 ->
   - {vd,vc,vb,va} steps 0..15, each held 4 cycles starting at cycle 1;
   - done=1 only in cycle 65;
   - truth=16'h8000, pass=1.
3. DUT model outa=va^vb^vc^vd, EXPECTED=16'h8000 ->
   - truth=16'h6996, pass=0;
   - with SYSTEM2_SWEEP_FAIL_IDX_EN: fail_valid=1, fail_idx=1.
4. Second start pulse at cycle 10 of a sweep -> ignored; done still only in cycle 65 and the vector sequence is unchanged.
5. rst=1 at cycle 20 mid-sweep -> next cycle busy=0, va..vd=0, truth=0, no done pulse. A new start then begins again at vector 0.
6. SETTLE_CYCLES=0, AND model -> each vector held 2 cycles, done in cycle 33, truth=16'h8000.

Source files
------------

// File: rtl/system2_sweep_pkg.sv
// -----------------------------------------------------------------------------
// system2_sweep_pkg
// Shared definitions for the system2 self-test sweep controller:
//   - state_t      : sweep FSM state encoding (3 bits)
//   - NUM_VECTORS  : number of input combinations of system2 (16)
//   - VEC_W        : width of the vector index / {vd,vc,vb,va} (4)
//   - CNT_W        : width of the settle down-counter (4, covers 0..15)
// -----------------------------------------------------------------------------
package system2_sweep_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/system2_settle_timer.sv
// -----------------------------------------------------------------------------
// system2_settle_timer
// Loadable saturating down-counter that times the SETTLE phase.
// Loading presets the count so that the zero flag rises in the last of
// SETTLE_CYCLES consecutive cycles after the load.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   load  in   preset the counter (asserted for one cycle before SETTLE)
//   zero  out  counter has reached zero (SETTLE ends this cycle)
// -----------------------------------------------------------------------------
module system2_settle_timer
    import system2_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    // SETTLE spans the cycle where the count is LOAD_VAL down to the cycle
    // where it is 0, i.e. SETTLE_CYCLES cycles in total.
    localparam logic [CNT_W-1:0] LOAD_VAL =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/system2_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// system2_sweep_ctrl
// Self-test sequencer for the 4-input combinational system2 block. On start it
// walks {vd,vc,vb,va} through indices 0..15, holds each vector for
// SETTLE_CYCLES idle cycles, samples outa into a 16-bit truth table and
// compares the table with EXPECTED.
//
// Optional feature macro: SYSTEM2_SWEEP_FAIL_IDX_EN
//   When defined, adds fail_valid / fail_idx reporting the first vector whose
//   sampled outa differs from EXPECTED.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   start       in   sweep request, sampled only in IDLE
//   outa_in     in   outa from system2
//   va..vd      out  vector bits 0..3 (index[0]..index[3])
//   busy        out  sweep in progress (DRIVE/SETTLE/SAMPLE)
//   done        out  one-cycle pulse when the sweep completes
//   truth[15:0] out  captured truth table, bit i = outa for index i
//   pass        out  truth == EXPECTED, valid from done until next start
//   fail_valid  out  (macro) a mismatch has been seen this sweep
//   fail_idx    out  (macro) index of the first mismatch
// -----------------------------------------------------------------------------
module system2_sweep_ctrl
    import system2_sweep_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        outa_in,
    output logic        va,
    output logic        vb,
    output logic        vc,
    output logic        vd,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic        pass
`ifdef SYSTEM2_SWEEP_FAIL_IDX_EN
    ,
    output logic        fail_valid,
    output logic [3:0]  fail_idx
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    state_t               state;
    state_t               state_next;
    logic [VEC_W-1:0]     index;
    logic [VEC_W-1:0]     vec;
    logic                 settle_load;
    logic                 settle_zero;
    logic [NUM_VECTORS-1:0] truth_sampled;

    system2_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .load (settle_load),
        .zero (settle_zero)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        settle_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                settle_load = 1'b1;
                state_next  = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_SAMPLE;
            end
            ST_SETTLE: begin
                if (settle_zero) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                state_next = (index == LAST_IDX) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Truth table including the bit being captured this cycle, so pass can be
    // registered on the SAMPLE->DONE edge and already be valid while done=1.
    always_comb begin
        truth_sampled        = truth;
        truth_sampled[index] = outa_in;
    end

    // ------------------------------------------------------------------
    // Index counter, vector register, truth table and verdict
    // ------------------------------------------------------------------
    // The vector register is loaded on the edge that enters DRIVE, so the new
    // vector is already on va..vd during the DRIVE cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
            vec   <= '0;
            truth <= '0;
            pass  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        index <= '0;
                        vec   <= '0;
                        truth <= '0;
                        pass  <= 1'b0;
                    end
                end
                ST_SAMPLE: begin
                    truth <= truth_sampled;
                    if (index == LAST_IDX) begin
                        vec  <= '0;
                        pass <= (truth_sampled == EXPECTED);
                    end else begin
                        index <= index + 1'b1;
                        vec   <= index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SYSTEM2_SWEEP_FAIL_IDX_EN
    // First-mismatch capture; later mismatches leave the record untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else if (state == ST_IDLE && start) begin
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else if (state == ST_SAMPLE && outa_in != EXPECTED[index] && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_idx   <= index;
        end
    end
`endif

    assign busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);
    assign va   = vec[0];
    assign vb   = vec[1];
    assign vc   = vec[2];
    assign vd   = vec[3];

endmodule
